// File: rtl/input_tile_mem.sv
// On-chip store for 6x6 int8 input tiles: loaded one row per cycle, then serves
// two tiles per request with one cycle of latency for the Winograd input transform.
module input_tile_mem #(
    parameter int DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start_i,
    input  logic              wr_en_i,
    input  logic signed [7:0] wr_row_i [6],
    input  logic              load_done_i,
    output logic [8:0]        tile_count_o,
    output logic              mem_ready_o,
    output logic              overflow_o,
    input  logic [7:0]        input_addr_i_1,
    input  logic [7:0]        input_addr_i_2,
    input  logic              input_request_i,
    output logic signed [7:0] input_data_o_1 [6][6],
    output logic signed [7:0] input_data_o_2 [6][6],
    output logic              input_valid_o,
    output logic              addr_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [8:0]  tile_count_r;
    logic [2:0]  row_cnt_r;
    logic        overflow_r;
    logic        valid_r;
    logic        addr_err_r;
    logic [47:0] mem_r   [DEPTH][6];
    logic [47:0] data1_r [6];
    logic [47:0] data2_r [6];
    logic [47:0] rd1_s   [6];
    logic [47:0] rd2_s   [6];
    logic [47:0] wr_row_s;
    logic        full_s;
    logic        wr_req_s;
    logic        wr_s;
    logic        ovf_s;
    logic        rd_s;
    logic        hit1_s;
    logic        hit2_s;

    assign full_s   = (tile_count_r == 9'(DEPTH));
    // load_start and load_done both pre-empt a write issued in the same cycle
    assign wr_req_s = (state_r == LOAD) && wr_en_i && !load_start_i && !load_done_i;
    assign wr_s     = wr_req_s && !full_s;
    assign ovf_s    = wr_req_s && full_s;
    assign rd_s     = (state_r == READY) && input_request_i && !load_start_i;
    assign hit1_s   = ({1'b0, input_addr_i_1} < tile_count_r);
    assign hit2_s   = ({1'b0, input_addr_i_2} < tile_count_r);

    for (genvar c = 0; c < 6; c++) begin : g_wr_pack
        assign wr_row_s[8*c +: 8] = wr_row_i[c];
    end

    // Out-of-range ports read as an all-zero tile.
    for (genvar r = 0; r < 6; r++) begin : g_rd
        assign rd1_s[r] = hit1_s ? mem_r[input_addr_i_1[AW-1:0]][r] : 48'd0;
        assign rd2_s[r] = hit2_s ? mem_r[input_addr_i_2[AW-1:0]][r] : 48'd0;
        for (genvar c = 0; c < 6; c++) begin : g_col
            assign input_data_o_1[r][c] = data1_r[r][8*c +: 8];
            assign input_data_o_2[r][c] = data2_r[r][8*c +: 8];
        end
    end

    // Next-state logic; load_start wins over load_done.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_start_i) state_s = LOAD;
                else              state_s = IDLE;
            end
            LOAD: begin
                if (load_start_i)     state_s = LOAD;
                else if (load_done_i) state_s = READY;
                else                  state_s = LOAD;
            end
            READY: begin
                if (load_start_i) state_s = LOAD;
                else              state_s = READY;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, tile/row counters and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            tile_count_r <= 9'd0;
            row_cnt_r    <= 3'd0;
            overflow_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (load_start_i) begin
                tile_count_r <= 9'd0;
                row_cnt_r    <= 3'd0;
                overflow_r   <= 1'b0;
            end else if ((state_r == LOAD) && load_done_i) begin
                row_cnt_r <= 3'd0;
            end else if (wr_s) begin
                if (row_cnt_r == 3'd5) begin
                    row_cnt_r    <= 3'd0;
                    tile_count_r <= tile_count_r + 9'd1;
                end else begin
                    row_cnt_r <= row_cnt_r + 3'd1;
                end
            end else if (ovf_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Tile storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[tile_count_r[AW-1:0]][row_cnt_r] <= wr_row_s;
        end
    end

    // Read pipeline stage: data holds while valid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r    <= 1'b0;
            addr_err_r <= 1'b0;
            data1_r    <= '{default: 48'd0};
            data2_r    <= '{default: 48'd0};
        end else begin
            valid_r    <= rd_s;
            addr_err_r <= rd_s && !(hit1_s && hit2_s);
            if (rd_s) begin
                data1_r <= rd1_s;
                data2_r <= rd2_s;
            end
        end
    end

    assign tile_count_o  = tile_count_r;
    assign mem_ready_o   = (state_r == READY);
    assign overflow_o    = overflow_r;
    assign input_valid_o = valid_r;
    assign addr_err_o    = addr_err_r;

endmodule

// File: tb/tb_input_tile_mem.sv
// Self-checking bench for input_tile_mem: scoreboard of expected read tiles,
// plus a DEPTH=2 instance sharing the stimulus for the full/overflow case.
module tb_input_tile_mem;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_start, wr_en, load_done, request;
    logic signed [7:0] wr_row [6];
    logic [7:0]        addr1, addr2;

    logic [8:0]        tile_count, tile_count_b;
    logic              mem_ready, overflow, valid, addr_err;
    logic              mem_ready_b, overflow_b, valid_b, addr_err_b;
    logic signed [7:0] data1 [6][6];
    logic signed [7:0] data2 [6][6];
    logic signed [7:0] data1_b [6][6];
    logic signed [7:0] data2_b [6][6];

    typedef struct packed {
        logic [287:0] t1;
        logic [287:0] t2;
        logic         err;
    } exp_t;

    exp_t         sb [$];
    logic [287:0] model_mem [256];
    int           model_cnt = 0;
    int           model_row = 0;
    int           checks = 0;
    int           errors = 0;
    logic [287:0] mon_a1, mon_a2;
    exp_t         mon_e;

    always #5 clk = ~clk;

    input_tile_mem #(.DEPTH(256)) dut (
        .clk(clk), .reset(reset), .load_start_i(load_start), .wr_en_i(wr_en),
        .wr_row_i(wr_row), .load_done_i(load_done), .tile_count_o(tile_count),
        .mem_ready_o(mem_ready), .overflow_o(overflow), .input_addr_i_1(addr1),
        .input_addr_i_2(addr2), .input_request_i(request), .input_data_o_1(data1),
        .input_data_o_2(data2), .input_valid_o(valid), .addr_err_o(addr_err)
    );

    input_tile_mem #(.DEPTH(2)) dut_small (
        .clk(clk), .reset(reset), .load_start_i(load_start), .wr_en_i(wr_en),
        .wr_row_i(wr_row), .load_done_i(load_done), .tile_count_o(tile_count_b),
        .mem_ready_o(mem_ready_b), .overflow_o(overflow_b), .input_addr_i_1(addr1),
        .input_addr_i_2(addr2), .input_request_i(request), .input_data_o_1(data1_b),
        .input_data_o_2(data2_b), .input_valid_o(valid_b), .addr_err_o(addr_err_b)
    );

    // Scoreboard monitor: every valid must match the oldest pending request.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            for (int r = 0; r < 6; r++) begin
                for (int c = 0; c < 6; c++) begin
                    mon_a1[(r*6+c)*8 +: 8] = data1[r][c];
                    mon_a2[(r*6+c)*8 +: 8] = data2[r][c];
                end
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got valid=1, required no valid (no pending request)");
            end else begin
                mon_e = sb.pop_front();
                if ({mon_a1, mon_a2, addr_err} !== {mon_e.t1, mon_e.t2, mon_e.err}) begin
                    errors++;
                    $display("FAIL read_data: got p1=%h p2=%h err=%b, required p1=%h p2=%h err=%b",
                             mon_a1, mon_a2, addr_err, mon_e.t1, mon_e.t2, mon_e.err);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        model_cnt  = 0;
        model_row  = 0;
    endtask

    task automatic pulse_done;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        model_row = 0;
    endtask

    task automatic write_row(input int base);
        wr_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            wr_row[c] = 8'(base + c);
            model_mem[model_cnt][(model_row*6+c)*8 +: 8] = 8'(base + c);
        end
        tick();
        wr_en = 1'b0;
        model_row++;
        if (model_row == 6) begin
            model_row = 0;
            model_cnt++;
        end
    endtask

    // Element [r][c] of tile t = seed + t*36 + r*6 + c - 72, wrapped to int8.
    task automatic write_tile(input int t, input int seed);
        for (int r = 0; r < 6; r++) write_row(seed + t*36 + r*6 - 72);
    endtask

    task automatic issue(input logic [7:0] a1, input logic [7:0] a2);
        exp_t e;
        addr1   = a1;
        addr2   = a2;
        request = 1'b1;
        e.t1    = (int'(a1) < model_cnt) ? model_mem[a1] : 288'd0;
        e.t2    = (int'(a2) < model_cnt) ? model_mem[a2] : 288'd0;
        e.err   = (int'(a1) >= model_cnt) || (int'(a2) >= model_cnt);
        sb.push_back(e);
        tick();
    endtask

    task automatic end_requests;
        request = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending requests without valid, required 0", sb.size());
        end
    endtask

    task automatic test_reset;
        logic any_nz;
        any_nz = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                any_nz = any_nz | (|data1[r][c]) | (|data2[r][c]);
        checks++; if (tile_count !== 9'd0) begin errors++; $display("FAIL rst_tile_count: got %0d, required 0", tile_count); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready: got %b, required 0", mem_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", valid); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err: got %b, required 0", addr_err); end
        checks++; if (any_nz !== 1'b0) begin errors++; $display("FAIL rst_data: got nonzero data, required all zero"); end
    endtask

    task automatic test_load_read;
        pulse_start();
        for (int t = 0; t < 4; t++) write_tile(t, 0);
        pulse_done();
        checks++; if (tile_count !== 9'd4) begin errors++; $display("FAIL lr_tile_count: got %0d, required 4", tile_count); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL lr_mem_ready: got %b, required 1", mem_ready); end
        issue(8'd0, 8'd1);
        issue(8'd2, 8'd3);
        issue(8'd3, 8'd4);
        issue(8'd0, 8'd0);
        end_requests();
        // Last read was 0/0: tile 0 holds on both ports after valid drops.
        checks++; if (data1[0][0] !== 8'hB8) begin errors++; $display("FAIL hold_p1_00: got %h, required b8", data1[0][0]); end
        checks++; if (data1[5][5] !== 8'hDB) begin errors++; $display("FAIL hold_p1_55: got %h, required db", data1[5][5]); end
        checks++; if (data2[0][0] !== 8'hB8) begin errors++; $display("FAIL hold_p2_00: got %h, required b8", data2[0][0]); end
    endtask

    task automatic test_partial;
        pulse_start();
        write_tile(0, 0);
        write_row(36 - 72);
        write_row(36 + 6 - 72);
        pulse_done();
        checks++; if (tile_count !== 9'd1) begin errors++; $display("FAIL partial_tile_count: got %0d, required 1", tile_count); end
        issue(8'd0, 8'd1);
        end_requests();
    endtask

    task automatic test_overflow;
        pulse_start();
        for (int t = 0; t < 3; t++) write_tile(t, 0);
        checks++; if (tile_count_b !== 9'd2) begin errors++; $display("FAIL ovf_tile_count: got %0d, required 2", tile_count_b); end
        checks++; if (overflow_b !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow_b); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_big_clear: got %b, required 0", overflow); end
        checks++; if (tile_count !== 9'd3) begin errors++; $display("FAIL ovf_big_count: got %0d, required 3", tile_count); end
        tick();
        tick();
        checks++; if (overflow_b !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow_b); end
        pulse_start();
        checks++; if (overflow_b !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b, required 0", overflow_b); end
        checks++; if (tile_count_b !== 9'd0) begin errors++; $display("FAIL ovf_count_cleared: got %0d, required 0", tile_count_b); end
    endtask

    task automatic test_no_read;
        addr1   = 8'd0;
        addr2   = 8'd0;
        request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL load_no_valid: got %b at cycle %0d, required 0", valid, i); end
        end
        request = 1'b0;
        write_tile(0, 0);
        pulse_done();
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL nr_ready: got %b, required 1", mem_ready); end
        load_start = 1'b1;
        load_done  = 1'b1;
        request    = 1'b1;
        tick();
        load_start = 1'b0;
        load_done  = 1'b0;
        model_cnt  = 0;
        model_row  = 0;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL both_ready: got %b, required 0", mem_ready); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL both_valid: got %b, required 0", valid); end
        checks++; if (tile_count !== 9'd0) begin errors++; $display("FAIL both_count: got %0d, required 0", tile_count); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL both_valid2: got %b, required 0", valid); end
        request = 1'b0;
    endtask

    task automatic test_reset_mid_load;
        pulse_start();
        write_tile(0, 50);
        for (int r = 0; r < 3; r++) write_row(50 + 36 + r*6 - 72);
        checks++; if (tile_count !== 9'd1) begin errors++; $display("FAIL mid_pre_count: got %0d, required 1", tile_count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (tile_count !== 9'd0) begin errors++; $display("FAIL mid_rst_count: got %0d, required 0", tile_count); end
        checks++; if (data1[0][0] !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h, required 00", data1[0][0]); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b, required 0", mem_ready); end
        tick();
        reset     = 1'b0;
        model_cnt = 0;
        model_row = 0;
        pulse_start();
        write_tile(0, 0);
        pulse_done();
        checks++; if (tile_count !== 9'd1) begin errors++; $display("FAIL mid_reload_count: got %0d, required 1", tile_count); end
        issue(8'd0, 8'd0);
        end_requests();
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        wr_en      = 1'b0;
        load_done  = 1'b0;
        request    = 1'b0;
        addr1      = 8'd0;
        addr2      = 8'd0;
        for (int c = 0; c < 6; c++) wr_row[c] = 8'sd0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_load_read();
        test_partial();
        test_overflow();
        test_no_read();
        test_reset_mid_load();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_tile_mem.md
# input_tile_mem

On-chip input-tile store that answers the input data controller's dual-address tile requests. It is loaded off-chip with 6x6 signed int8 tiles, streamed one row per cycle. It then serves two tiles per request with a fixed one-cycle latency and a valid strobe. It is the memory-side responder of the input_addr/input_request/input_valid interface that feeds the Winograd input transform.

## Interface
Parameters:
- DEPTH, 256, tile capacity (1..256; addresses are 8 bits)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- load_start_i  in  1  begin a new load; clears stored tile count
- wr_en_i  in  1  write one tile row this cycle
- wr_row_i  in  signed [7:0] x[5:0]  row data, element j = column j
- load_done_i  in  1  end load, enter serving state
- tile_count_o  out  9  number of complete tiles stored
- mem_ready_o  out  1  high in READY state
- overflow_o  out  1  sticky: a write was attempted while full
- input_addr_i_1  in  8  tile address, port 1
- input_addr_i_2  in  8  tile address, port 2
- input_request_i  in  1  read request for both addresses
- input_data_o_1  out  signed [7:0] x[5:0][5:0]  tile for port 1, [row][col]
- input_data_o_2  out  signed [7:0] x[5:0][5:0]  tile for port 2
- input_valid_o  out  1  data outputs valid this cycle
- addr_err_o  out  1  pulse: an address in the returned pair was out of range

## Operation
- States: IDLE (after reset), LOAD, READY.
- IDLE→LOAD on load_start_i. LOAD→READY on load_done_i. READY→LOAD on load_start_i. No other transitions.
- If load_start_i and load_done_i are both high, load_start_i wins.
- Entering LOAD clears tile_count, row_cnt and overflow_o.
- Entering LOAD also forces input_valid_o=0 the next cycle, flushing any in-flight read.
- LOAD writes: each wr_en_i cycle stores wr_row_i into row row_cnt of tile tile_count.
  - row_cnt (3 bits, 0..5) increments on each write.
  - At row_cnt==5, row_cnt→0 and tile_count increments. The tile is readable only once committed.
- Full: when tile_count==DEPTH, a write is dropped and sets overflow_o. overflow_o holds until the next load_start_i or reset.
- wr_en_i outside LOAD is ignored.
- load_done_i with row_cnt≠0 discards the partial tile: row_cnt→0 and tile_count is unchanged.
- Reads are serviced only in READY. input_request_i in IDLE or LOAD produces no valid.
- Per-port range check: an address ≥ tile_count returns an all-zero tile on that port and raises addr_err_o with the valid.
- Ports are independent. Both may name the same address.
- Stored contents are not cleared by load_start_i; unwritten tiles are unreachable through the range check.

## Timing
- Reset values:
  - state=IDLE, mem_ready_o=0, tile_count_o=0, overflow_o=0.
  - input_valid_o=0, addr_err_o=0.
  - input_data_o_1/2 all zero.
  - row_cnt=0.
  - Memory array is not reset.
- Read latency is 1 cycle. A request sampled high at edge N in READY registers both tiles and sets input_valid_o=1 after edge N (valid during cycle N+1).
- Fully pipelined: back-to-back requests produce back-to-back valids, each carrying the addresses sampled at its own request edge.
- input_valid_o and addr_err_o are single-cycle pulses per request. Data outputs hold their last value when valid is low.
- The requester holds input_request_i while waiting for data and captures on input_valid_o && input_request_i. This block needs no acknowledge beyond valid.
- tile_count_o and mem_ready_o update at the edge following the triggering event.
- Write-then-read: a tile committed at edge N is readable by a request sampled at edge N+1 or later, once READY.
- Asynchronous reset mid-load or mid-read immediately zeroes all outputs and returns to IDLE. The partial load is lost.

## Test plan
- Load 4 tiles, where element [r][c] of tile t = t*36+r*6+c-72 (wrapped to int8), then load_done. Request addr1=0/addr2=1, then 2/3 on consecutive cycles -> two consecutive valids with exact tiles, addr_err_o=0, tile_count_o=4.
- After a 4-tile load, request addr1=3/addr2=4 -> port1 returns tile 3, port2 all zeros, addr_err_o=1 with valid. Request 0/0 -> identical tiles on both ports.
- Write 8 rows (1 full tile + 2 rows), then load_done -> tile_count_o=1. Request 0/1 -> tile 0 data, port2 zeros, addr_err_o=1.
- With DEPTH=2, write 3 tiles -> tile_count_o=2, overflow_o=1 sticky. load_start_i -> overflow_o=0, tile_count_o=0.
- Request held in LOAD for 3 cycles -> no valid. Assert load_start_i and load_done_i together in READY -> state LOAD, mem_ready_o=0. A request issued the cycle before gives no valid.
- Assert reset mid-load after 3 rows, then reload 1 tile and read 0/0 -> correct tile. The earlier partial rows do not appear.
